// File: rtl/dm_ctrl_if.sv
// dm_ctrl_if: request/response bus between an LSU (master) and dm_ctrl (slave).
//   req/we/op/addr/wdata/pc : access request driven by the master
//   ready/done/rdata/exc    : handshake and completion returned by the slave
interface dm_ctrl_if;
    logic        req;
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic [4:0]  exc;
    modport master (output req, we, op, addr, wdata, pc, input ready, done, rdata, exc);
    modport slave (input req, we, op, addr, wdata, pc, output ready, done, rdata, exc);
endinterface

// File: rtl/dm_ctrl.sv
// dm_ctrl: word-organised data memory with byte/half/word access, fixed wait states and address exceptions.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (memory contents are kept)
//   bus   : dm_ctrl_if slave (req/we/op/addr/wdata/pc in, ready/done/rdata/exc out)
//   DM_TRACE_EN : when defined, each committed store prints "<time>@<pc>: *<word addr> <= <word>"
module dm_ctrl #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input logic       clk,
    input logic       reset,
    dm_ctrl_if.slave  bus
);
    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LAST  = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS) - 33'd1;
    localparam logic [3:0]  WLOAD = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state, state_n;
    logic [3:0]  cnt;
    logic        r_we;
    logic [2:0]  r_op;
    logic [31:0] r_addr, r_wdata;
    logic [31:0] rdata_q;
    logic [4:0]  exc_q;
    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};
    logic        accept, enter_resp, commit, flag;
    logic        a_we, is_half, is_byte, is_signed;
    logic [2:0]  a_op;
    logic [31:0] a_addr, a_wdata;
    logic [AW-1:0] idx;
    logic [31:0] cur, rep, merged, load_val;
    logic [3:0]  be;
    logic [15:0] h;
    logic [7:0]  b;

    assign accept     = bus.req && state != WAIT;
    // With no wait states the access completes on its own accept edge, so it
    // must be served straight from the bus rather than from the capture registers.
    assign enter_resp = (accept && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
    assign a_we       = WAIT_CYCLES == 0 ? bus.we    : r_we;
    assign a_op       = WAIT_CYCLES == 0 ? bus.op    : r_op;
    assign a_addr     = WAIT_CYCLES == 0 ? bus.addr  : r_addr;
    assign a_wdata    = WAIT_CYCLES == 0 ? bus.wdata : r_wdata;

    assign is_half   = a_op == 3'd1 || a_op == 3'd2;
    assign is_byte   = a_op == 3'd3 || a_op == 3'd4;
    assign is_signed = a_op == 3'd1 || a_op == 3'd3;
    assign flag      = (!is_half && !is_byte && a_addr[1:0] != 2'b00) || (is_half && a_addr[0])
                     || a_addr < BASE_ADDR || {1'b0, a_addr} > LAST;
    assign commit    = enter_resp && a_we && !flag;

    // BASE_ADDR is aligned to the array size, so the low address bits index it directly.
    assign idx = a_addr[AW+1:2];
    assign cur = mem[idx];
    assign be  = is_byte ? 4'b0001 << a_addr[1:0] : is_half ? (a_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign rep = is_byte ? {4{a_wdata[7:0]}} : is_half ? {2{a_wdata[15:0]}} : a_wdata;
    assign h   = a_addr[1] ? cur[31:16] : cur[15:0];
    assign b   = cur[{a_addr[1:0], 3'b000} +: 8];
    assign load_val = is_byte ? {{24{is_signed & b[7]}}, b}
                    : is_half ? {{16{is_signed & h[15]}}, h} : cur;

    always_comb begin
        merged = cur;
        for (int i = 0; i < 4; i++)
            if (be[i]) merged[8*i +: 8] = rep[8*i +: 8];
    end

    always_ff @(posedge clk)
        if (commit && !reset) mem[idx] <= merged;

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;

    always_comb
        state_n = state == WAIT ? (cnt == 4'd0 ? RESP : WAIT)
                : accept ? (WAIT_CYCLES == 0 ? RESP : WAIT) : IDLE;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt     <= '0;
            r_we    <= 1'b0;
            r_op    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            rdata_q <= '0;
            exc_q   <= '0;
        end else begin
            if (accept) begin
                cnt     <= WLOAD;
                r_we    <= bus.we;
                r_op    <= bus.op;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
            end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (enter_resp) begin
                rdata_q <= (flag || a_we) ? 32'd0 : load_val;
                exc_q   <= flag ? (a_we ? 5'd5 : 5'd4) : 5'd0;
            end
        end

    always_comb begin
        bus.ready = state != WAIT;
        bus.done  = state == RESP;
        bus.rdata = state == RESP ? rdata_q : 32'd0;
        bus.exc   = state == RESP ? exc_q : 5'd0;
    end

`ifdef DM_TRACE_EN
    logic [31:0] r_pc, a_pc;
    always_ff @(posedge clk or posedge reset)
        if (reset) r_pc <= '0;
        else if (accept) r_pc <= bus.pc;
    assign a_pc = WAIT_CYCLES == 0 ? bus.pc : r_pc;
    always_ff @(posedge clk)
        if (commit && !reset) $display("%0t@%08h: *%08h <= %08h", $time, a_pc, {a_addr[31:2], 2'b00}, merged);
`endif
endmodule
